// File: rtl/axil_regfile.sv
// AXI4-Lite register file: NUM_REGS x DATA_W, independent AW/W capture, one outstanding write and one outstanding read; B and R are returned one edge after the handshake and held until BREADY/RREADY.
// Optional AXIL_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int ADDR_LSB = $clog2(DATA_W/8);
  localparam int STRB_W   = DATA_W/8;
  localparam int IDX_W    = ADDR_W - ADDR_LSB;

  logic                       aw_full;
  logic                       w_full;
  logic                       commit;
  logic [IDX_W-1:0]           aw_idx;
  logic [IDX_W-1:0]           ar_idx;
  logic [DATA_W-1:0]          w_data;
  logic [STRB_W-1:0]          w_strb;
  logic [DATA_W-1:0]          rd_val;
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic [1:0]                 bresp_nxt;
  logic [1:0]                 rresp_nxt;
  logic                       unused_addr_lsbs;

  assign AWREADY = !ARESET && !aw_full && !BVALID;
  assign WREADY  = !ARESET && !w_full && !BVALID;
  assign ARREADY = !ARESET && !RVALID;
  assign commit  = aw_full && w_full && !BVALID;
  assign ar_idx  = ARADDR[ADDR_W-1:ADDR_LSB];
  assign reg_o   = regs;
  assign unused_addr_lsbs = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  // Out-of-range indices match no register, so the read value stays zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_val = regs[i*DATA_W +: DATA_W];
    end
  end

`ifdef AXIL_SLVERR_EN
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(NUM_REGS);
  assign bresp_nxt = ({1'b0, aw_idx} < NUM_REGS_L) ? 2'b00 : 2'b10;
  assign rresp_nxt = ({1'b0, ar_idx} < NUM_REGS_L) ? 2'b00 : 2'b10;
`else
  assign bresp_nxt = 2'b00;
  assign rresp_nxt = 2'b00;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      aw_idx     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      regs       <= '0;
      wr_pulse_o <= '0;
      BVALID     <= 1'b0;
      BRESP      <= 2'b00;
      RVALID     <= 1'b0;
      RDATA      <= '0;
      RRESP      <= 2'b00;
    end else begin
      wr_pulse_o <= '0;
      if (AWVALID && AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= AWADDR[ADDR_W-1:ADDR_LSB];
      end
      if (WVALID && WREADY) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      // Commit cannot coincide with a new AW/W capture: the flags block the readies.
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        BVALID  <= 1'b1;
        BRESP   <= bresp_nxt;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx == IDX_W'(i)) begin
            wr_pulse_o[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb[b]) regs[i*DATA_W + b*8 +: 8] <= w_data[b*8 +: 8];
            end
          end
        end
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= rd_val;
        RRESP  <= rresp_nxt;
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_regfile.sv
// Bench for axil_regfile: directed vector table, hand sequences for stall/ordering/reset corners, random traffic against an array model.
module tb_axil_regfile;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 8;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic                       ACLK;
  logic                       ARESET;
  logic [ADDR_W-1:0]          AWADDR;
  logic                       AWVALID;
  logic                       AWREADY;
  logic [DATA_W-1:0]          WDATA;
  logic [DATA_W/8-1:0]        WSTRB;
  logic                       WVALID;
  logic                       WREADY;
  logic [1:0]                 BRESP;
  logic                       BVALID;
  logic                       BREADY;
  logic [ADDR_W-1:0]          ARADDR;
  logic                       ARVALID;
  logic                       ARREADY;
  logic [DATA_W-1:0]          RDATA;
  logic [1:0]                 RRESP;
  logic                       RVALID;
  logic                       RREADY;
  logic [NUM_REGS*DATA_W-1:0] reg_o;
  logic [NUM_REGS-1:0]        wr_pulse_o;

  axil_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [NUM_REGS];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] r = '0;
    for (int i = 0; i < NUM_REGS; i++) r[i*32 +: 32] = mregs[i];
    return r;
  endfunction

  function automatic logic in_range(input logic [5:0] addr);
    return int'(addr[5:2]) < NUM_REGS;
  endfunction

  function automatic logic [31:0] model_read(input logic [5:0] addr);
    return in_range(addr) ? mregs[addr[5:2]] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [5:0] addr);
    return in_range(addr) ? 2'b00 : OOR_RESP;
  endfunction

  function automatic logic [7:0] model_pulse(input logic [5:0] addr);
    return in_range(addr) ? (8'h01 << addr[5:2]) : 8'h00;
  endfunction

  task automatic model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (in_range(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) mregs[addr[5:2]][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp, output logic [7:0] pulse);
    logic aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    int c = 0;
    AWADDR = addr; WDATA = data; WSTRB = strb; BREADY = 1'b0;
    while (!(aw_done && w_done) && c < 40) begin
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      c++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    check("aw_w_handshake", {aw_done, w_done}, 2'b11);
    check("bvalid_before_commit", BVALID, 1'b0);
    tick();
    check("bvalid_after_commit", BVALID, 1'b1);
    resp = BRESP;
    pulse = wr_pulse_o;
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("b_hold", {BVALID, BRESP, AWREADY, WREADY}, {1'b1, resp, 2'b00});
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("b_done", {BVALID, wr_pulse_o}, 9'h0);
  endtask

  task automatic do_read(input logic [5:0] addr, input int r_dly, output logic [31:0] data, output logic [1:0] resp);
    ARADDR = addr; ARVALID = 1'b1;
    check("arready_idle", ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    check("rvalid_latency", RVALID, 1'b1);
    data = RDATA;
    resp = RRESP;
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("r_hold", {RVALID, RRESP, RDATA, ARREADY}, {1'b1, resp, data, 1'b0});
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("r_done", {RVALID, ARREADY}, 2'b01);
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [7:0]  exp_pulse;
    logic        oor;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic [1:0]  resp;
    logic [7:0]  pulse;
    logic [31:0] rd;

    vecs[0] = '{6'h04, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 8'h02, 1'b0};
    vecs[1] = '{6'h08, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD, 8'h04, 1'b0};
    vecs[2] = '{6'h00, 32'h12345678, 4'h3, 32'h00005678, 8'h01, 1'b0};
    vecs[3] = '{6'h1F, 32'hCAFEF00D, 4'hC, 32'hCAFE0000, 8'h80, 1'b0};
    vecs[4] = '{6'h06, 32'h00000000, 4'h0, 32'hDEADBEEF, 8'h02, 1'b0};
    vecs[5] = '{6'h3C, 32'hFFFFFFFF, 4'hF, 32'h00000000, 8'h00, 1'b1};
    vecs[6] = '{6'h20, 32'hFFFFFFFF, 4'hF, 32'h00000000, 8'h00, 1'b1};
    vecs[7] = '{6'h1C, 32'h0F0F0F0F, 4'h6, 32'hCA0F0F00, 8'h80, 1'b0};

    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 32'h0;
    ARESET = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_ready_valid", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b00000);
    ARESET = 1'b0;
    tick();
    check("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    check("post_rst_valid", {BVALID, RVALID, wr_pulse_o}, 10'h0);
    check("post_rst_regs", reg_o, 256'h0);
    check("post_rst_data", {BRESP, RRESP, RDATA}, 36'h0);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp, pulse);
      model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      check($sformatf("vec%0d_bresp", i), resp, vecs[i].oor ? OOR_RESP : 2'b00);
      check($sformatf("vec%0d_pulse", i), pulse, vecs[i].exp_pulse);
      do_read(vecs[i].addr, 0, rd, resp);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_rresp", i), resp, vecs[i].oor ? OOR_RESP : 2'b00);
      check($sformatf("vec%0d_reg_o", i), reg_o, model_flat());
    end

    // W arrives three cycles before AW
    AWADDR = 6'h08; WDATA = 32'h11223344; WSTRB = 4'h5; BREADY = 1'b1;
    WVALID = 1'b1;
    check("wfirst_wready", WREADY, 1'b1);
    tick();
    WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wfirst_stall", {WREADY, AWREADY, BVALID}, 3'b010);
      tick();
    end
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("wfirst_no_early_b", BVALID, 1'b0);
    tick();
    check("wfirst_b", {BVALID, BRESP, wr_pulse_o}, {1'b1, 2'b00, 8'h04});
    tick();
    check("wfirst_reg2", reg_o[2*32 +: 32], 32'hAA22CC44);
    model_write(6'h08, 32'h11223344, 4'h5);

    // BREADY held low: second write must wait for the response handshake
    BREADY = 1'b0;
    AWADDR = 6'h0C; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    check("stall_bvalid", BVALID, 1'b1);
    model_write(6'h0C, 32'h55, 4'hF);
    AWADDR = 6'h10; WDATA = 32'h66;
    for (int i = 0; i < 5; i++) begin
      AWVALID = 1'b1; WVALID = 1'b1;
      check("stall_hold", {BVALID, BRESP, AWREADY, WREADY}, 5'b10000);
      tick();
    end
    BREADY = 1'b1;
    tick();
    check("stall_release", {BVALID, AWREADY, WREADY}, 3'b011);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    check("stall_second_b", {BVALID, wr_pulse_o}, {1'b1, 8'h10});
    model_write(6'h10, 32'h66, 4'hF);
    tick();
    BREADY = 1'b0;
    check("stall_regs", reg_o, model_flat());

    // Read and commit to the same register at the same edge
    do_write(6'h04, 32'h1, 4'hF, 0, 0, 0, resp, pulse);
    model_write(6'h04, 32'h1, 4'hF);
    AWADDR = 6'h04; WDATA = 32'h5; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 6'h04; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    check("same_edge_rdata", {RVALID, RDATA}, {1'b1, 32'h1});
    check("same_edge_commit", {BVALID, reg_o[32 +: 32]}, {1'b1, 32'h5});

    // Reset with a pending read response
    ARESET = 1'b1;
    tick();
    check("midrst_valids", {RVALID, BVALID, ARREADY, AWREADY}, 4'b0000);
    check("midrst_regs", reg_o, 256'h0);
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 32'h0;
    ARESET = 1'b0;
    tick();
    check("midrst_release", {ARREADY, AWREADY, WREADY, RDATA}, {3'b111, 32'h0});

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      logic [5:0] a;
      logic [31:0] d;
      logic [3:0] s;
      a = 6'($urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, pulse);
        check("rnd_bresp", resp, model_resp(a));
        check("rnd_pulse", pulse, model_pulse(a));
        model_write(a, d, s);
      end else begin
        do_read(a, $urandom_range(0, 2), rd, resp);
        check("rnd_rdata", rd, model_read(a));
        check("rnd_rresp", resp, model_resp(a));
      end
      if (it % 25 == 24) check("rnd_reg_o", reg_o, model_flat());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
Parametrised AXI4-Lite slave register file. It is the successor to the fixed 4x32-bit slave, with configurable data width, address width and register count. AW and W are accepted independently, with byte strobes. BREADY and RREADY backpressure are honoured, and a per-register write pulse is exported to downstream logic. It sits between the AXI4-Lite interconnect and peripheral control logic.

Parameters:
DATA_W, 32, data bus width in bits; legal values are 32 or 64.
ADDR_W, 6, AXI address width in bits.
NUM_REGS, 8, number of registers; range 1 to 2^(ADDR_W-ADDR_LSB).
ADDR_LSB (localparam), $clog2(DATA_W/8), number of byte-offset bits.

Ports:
ACLK  in  1  clock.
ARESET  in  1  synchronous, active-high reset.
AWADDR  in  ADDR_W  write address.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address ready.
WDATA  in  DATA_W  write data.
WSTRB  in  DATA_W/8  byte strobes.
WVALID  in  1  write data valid.
WREADY  out  1  write data ready.
BRESP  out  2  write response.
BVALID  out  1  write response valid.
BREADY  in  1  write response ready.
ARADDR  in  ADDR_W  read address.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address ready.
RDATA  out  DATA_W  read data.
RRESP  out  2  read response.
RVALID  out  1  read data valid.
RREADY  in  1  read data ready.
reg_o  out  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].
wr_pulse_o  out  NUM_REGS  one-cycle pulse on the register just written.

Behaviour:
- One clock, ACLK. Reset is synchronous and active-high on ARESET.
- Reset, sampled on a rising ACLK edge:
  - all registers = 0;
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0 during reset;
  - BRESP, RRESP, RDATA = 0; wr_pulse_o = 0;
  - all hold flags cleared.
  - Reset mid-transaction discards any held address/data and any pending response.
- Decode: idx = addr[ADDR_W-1:ADDR_LSB]. Low ADDR_LSB bits are ignored (no alignment error). The address is in range when idx < NUM_REGS.
- AW channel:
  - hold flag aw_full; AWREADY = !ARESET && !aw_full && !BVALID.
  - On AWVALID && AWREADY: latch AWADDR and set aw_full.
- W channel:
  - hold flag w_full; WREADY = !ARESET && !w_full && !BVALID.
  - On WVALID && WREADY: latch WDATA and WSTRB and set w_full.
- AW and W may arrive in either order or in the same cycle. An early channel stalls (READY=0) until its partner arrives and the write commits.
- Commit, at the edge where aw_full && w_full && !BVALID:
  - if in range, update each byte b of reg[idx] where WSTRB[b]=1; bytes with WSTRB[b]=0 are unchanged;
  - out-of-range writes are discarded;
  - clear aw_full and w_full; set BVALID=1; load BRESP;
  - wr_pulse_o[idx]=1 for exactly one cycle, in range only. WSTRB=0 still pulses.
- Write latency: AW and W handshake at edge N gives commit and BVALID at edge N+1.
- BVALID and BRESP are held stable until BREADY is sampled high, then BVALID deasserts. No new AW/W is accepted while BVALID=1; this gives one outstanding write.
- Read:
  - ARREADY = !ARESET && !RVALID.
  - On ARVALID && ARREADY at edge N: RDATA = reg[idx] (0 if out of range), RRESP loaded, RVALID=1 at N+1.
  - RDATA, RRESP and RVALID are held stable until RREADY; one outstanding read.
  - Back-to-back reads: ARREADY rises the cycle after the RVALID && RREADY handshake.
- Read and write channels are fully independent.
  - A read and a commit to the same register at the same edge: the read returns the pre-write value.
- reg_o is driven directly from the register flops, so a write is visible the cycle after commit.

Optional Feature:
AXIL_SLVERR_EN.
- Defined: out-of-range accesses return BRESP/RRESP = 2'b10 (SLVERR). Write behaviour and RDATA=0 are unchanged.
- Undefined: every response is 2'b00 (OKAY), including out-of-range accesses.

Test Plan:
- Reset, then no traffic: all ready/valid signals 0 while ARESET=1; after release AWREADY=WREADY=ARREADY=1, reg_o=0, BVALID=RVALID=0.
- AW(0x04) and W(0xDEADBEEF, WSTRB=0xF) in the same cycle, BREADY=1: BVALID 1 cycle later with BRESP=00, wr_pulse_o=8'b0000_0010, reg1=0xDEADBEEF. Then AR(0x04) gives RDATA=0xDEADBEEF, RRESP=00.
- W(0x11223344, WSTRB=0x5) 3 cycles before AW(0x08) onto reg2=0xAABBCCDD: WREADY drops after the W handshake and stalls until AW arrives; reg2 becomes 0xAA22CC44.
- BREADY held 0 for 5 cycles after a write: BVALID/BRESP stay stable, AWREADY=WREADY=0 throughout; a second write is accepted only after BREADY=1.
- Write AW(0x3C) with NUM_REGS=8, then AR(0x3C): no reg_o change and no wr_pulse_o; RDATA=0. BRESP/RRESP are 10 with AXIL_SLVERR_EN defined, 00 without.
- AR to reg1 at the same edge as a commit of 0x5 to reg1 (old value 0x1): RDATA=0x1. Then ARESET pulsed with RVALID=1 and RREADY=0: RVALID=0 and reg1=0 after reset.
